seven_seg_reader: RTL and testbench

- Receive-side counterpart of the team's seven-segment driver.
- Samples the seven active-low segment lines (la..lg) of a driven display, filters glitches and multi-segment transitions, and decodes the pattern back to a 4-bit digit.
- Presents the decoded digit on a valid/ready handshake.
- Used as a loopback checker for the display path and as a front end for decoding a panel under test.

---
 rtl/seven_seg_reader.sv | 155 +++++++++++++++
 tb/tb_seven_seg_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_reader.sv
// ============================================================================
// Module   : seven_seg_reader
// Brief    : Samples active-low seven-segment lines, filters them and decodes
//            the stable pattern to a 4-bit digit on a valid/ready interface.
//            Optional macro SEVEN_SEG_READER_HEX_EN accepts A..F as digits.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clock_in,
    input  logic       rst,
    input  logic       la,
    input  logic       lb,
    input  logic       lc,
    input  logic       ld,
    input  logic       le,
    input  logic       lf,
    input  logic       lg,
    input  logic       out_ready,
    output logic [3:0] digit,
    output logic       out_valid,
    output logic       blank,
    output logic       pattern_err,
    output logic       overrun
);

    localparam logic [6:0]       C_BLANK   = 7'b1111111;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_ACCEPT = 1'b1
    } state_t;

    state_t           state_q;
    logic [6:0]       sync1_q;
    logic [6:0]       s_q;
    logic [6:0]       s_prev_q;
    logic [6:0]       acc_pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       digit_q;
    logic             out_valid_q;
    logic             blank_q;
    logic             pattern_err_q;
    logic             overrun_q;

    logic [6:0]       seg;
    logic             dec_legal;
    logic [3:0]       dec_val;
    logic             accept;

    assign seg = {la, lb, lc, ld, le, lf, lg};

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'd0;
        case (s_q)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
`ifdef SEVEN_SEG_READER_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
`endif
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        if (s_q != s_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The s == s_prev term stops a counter still saturated from the previous
    // pattern from accepting a new pattern on its very first sample.
    assign accept = (s_q == s_prev_q) && (cnt_q == C_CNT_MAX) && (s_q != acc_pat_q);

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SETTLE;
            sync1_q       <= C_BLANK;
            s_q           <= C_BLANK;
            s_prev_q      <= C_BLANK;
            acc_pat_q     <= C_BLANK;
            cnt_q         <= '0;
            digit_q       <= 4'd0;
            out_valid_q   <= 1'b0;
            blank_q       <= 1'b1;
            pattern_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= seg;
            s_q           <= sync1_q;
            s_prev_q      <= s_q;
            cnt_q         <= cnt_d;
            pattern_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_SETTLE: begin
                    if (accept) begin
                        state_q   <= ST_ACCEPT;
                        acc_pat_q <= s_q;
                        if (dec_legal) begin
                            digit_q     <= dec_val;
                            out_valid_q <= 1'b1;
                            blank_q     <= 1'b0;
                            overrun_q   <= out_valid_q && !out_ready;
                        end else if (s_q == C_BLANK) begin
                            blank_q <= 1'b1;
                        end else begin
                            pattern_err_q <= 1'b1;
                        end
                    end
                end
                ST_ACCEPT: begin
                    state_q <= ST_SETTLE;
                end
            endcase
        end
    end

    assign digit       = digit_q;
    assign out_valid   = out_valid_q;
    assign blank       = blank_q;
    assign pattern_err = pattern_err_q;
    assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_reader.sv
// ============================================================================
// Module   : tb_seven_seg_reader
// Brief    : Self-checking bench for seven_seg_reader with a transfer scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seven_seg_reader;

    localparam int         STABLE_CYCLES = 4;
    localparam int         C_LAT         = STABLE_CYCLES + 2;
    localparam logic [6:0] P_BLANK       = 7'b1111111;
    localparam logic [6:0] P_1           = 7'b1001111;
    localparam logic [6:0] P_2           = 7'b0010010;
    localparam logic [6:0] P_3           = 7'b0000110;
    localparam logic [6:0] P_5           = 7'b0100100;
    localparam logic [6:0] P_8           = 7'b0000000;
    localparam logic [6:0] P_A           = 7'b0001000;
    localparam logic [6:0] P_BAD         = 7'b0101010;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       out_ready = 1'b0;
    logic [6:0] seg       = P_BLANK;
    logic [3:0] digit;
    logic       out_valid;
    logic       blank;
    logic       pattern_err;
    logic       overrun;

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         err_seen  = 0;
    int         ovr_seen  = 0;
    int         xfer_seen = 0;
    logic [3:0] sb[$];

    seven_seg_reader #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (3)
    ) u_dut (
        .clock_in   (clk),
        .rst        (rst),
        .la         (seg[6]),
        .lb         (seg[5]),
        .lc         (seg[4]),
        .ld         (seg[3]),
        .le         (seg[2]),
        .lf         (seg[1]),
        .lg         (seg[0]),
        .out_ready  (out_ready),
        .digit      (digit),
        .out_valid  (out_valid),
        .blank      (blank),
        .pattern_err(pattern_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples pulses and transfers mid-cycle, then advances to just after the next edge.
    task automatic tick();
        logic [3:0] e;
        @(negedge clk);
        if (pattern_err) err_seen++;
        if (overrun)     ovr_seen++;
        if (out_valid && out_ready) begin
            xfer_seen++;
            if (sb.size() == 0) begin
                check("xfer_unexpected", {28'd0, digit}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("xfer_digit", {28'd0, digit}, {28'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (lat < 0) begin
                tick();
                if (out_valid) lat = i - 1;
            end
        end
    endtask

    initial begin
        int lat;
        int e0;
        int o0;
        int x0;

        repeat (3) tick();
        check("rst_digit", {28'd0, digit}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_blank", {31'd0, blank}, 32'd1);
        check("rst_perr", {31'd0, pattern_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        // too-short pattern
        e0 = err_seen;
        seg = P_3;
        repeat (3) tick();
        seg = P_BLANK;
        repeat (12) tick();
        check("short_valid", {31'd0, out_valid}, 32'd0);
        check("short_perr", err_seen - e0, 32'd0);
        check("short_blank", {31'd0, blank}, 32'd1);

        // latency of a held "3"
        seg = P_3;
        sb.push_back(4'd3);
        wait_valid(lat);
        check("lat_3", lat, C_LAT);
        check("digit_3", {28'd0, digit}, 32'd3);
        check("blank_3", {31'd0, blank}, 32'd0);
        repeat (5) tick();
        check("hold_valid_3", {31'd0, out_valid}, 32'd1);
        check("hold_digit_3", {28'd0, digit}, 32'd3);

        // overwrite while unconsumed
        o0 = ovr_seen;
        seg = P_8;
        sb.delete();
        sb.push_back(4'd8);
        repeat (10) tick();
        check("ovr_pulse", ovr_seen - o0, 32'd1);
        check("ovr_digit", {28'd0, digit}, 32'd8);
        check("ovr_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_valid_8", {31'd0, out_valid}, 32'd0);

        // illegal pattern
        e0 = err_seen;
        seg = P_BAD;
        repeat (12) tick();
        check("bad_perr", err_seen - e0, 32'd1);
        check("bad_valid", {31'd0, out_valid}, 32'd0);
        check("bad_digit", {28'd0, digit}, 32'd8);
        check("bad_blank", {31'd0, blank}, 32'd0);

        // hex pattern "A"
        e0 = err_seen;
        seg = P_A;
`ifdef SEVEN_SEG_READER_HEX_EN
        sb.push_back(4'hA);
        repeat (12) tick();
        check("hexA_perr", err_seen - e0, 32'd0);
        check("hexA_digit", {28'd0, digit}, 32'd10);
        check("hexA_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        repeat (12) tick();
        check("hexA_perr", err_seen - e0, 32'd1);
        check("hexA_valid", {31'd0, out_valid}, 32'd0);
        check("hexA_digit", {28'd0, digit}, 32'd8);
`endif

        // blank pattern
        seg = P_BLANK;
        repeat (12) tick();
        check("blank_set", {31'd0, blank}, 32'd1);
        check("blank_valid", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-settle of "5"
        seg = P_5;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_digit", {28'd0, digit}, 32'd0);
        check("arst_blank", {31'd0, blank}, 32'd1);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        sb.push_back(4'd5);
        wait_valid(lat);
        check("lat_5", lat, C_LAT);
        check("digit_5", {28'd0, digit}, 32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_valid_5", {31'd0, out_valid}, 32'd0);

        // back-to-back transfers with out_ready held
        o0 = ovr_seen;
        x0 = xfer_seen;
        out_ready = 1'b1;
        seg = P_1;
        sb.push_back(4'd1);
        repeat (5) tick();
        seg = P_2;
        sb.push_back(4'd2);
        repeat (12) tick();
        out_ready = 1'b0;
        check("b2b_xfers", xfer_seen - x0, 32'd2);
        check("b2b_ovr", ovr_seen - o0, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_tests);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
